// File: rtl/tdm_demux4.sv
// Four-slot TDM serial demultiplexer: assembles sync-aligned 4-bit frames from a valid-qualified bit stream.
// Optional macro TDM_DEMUX_PARITY_EN adds a fifth (even-XOR) parity beat checked before dout is updated.
module tdm_demux4 #(
    parameter int IDLE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    input  logic       sync,
    output logic [3:0] dout,
    output logic       dout_valid,
    output logic [1:0] slot,
    output logic       err
);

`ifdef TDM_DEMUX_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_PAR} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RECV} state_t;
`endif

    localparam logic [7:0] LIMIT = 8'(IDLE_LIMIT);

    state_t     state_q;
    logic [3:0] frame_q;
    logic [3:0] dout_q;
    logic       dout_valid_q;
    logic       err_q;
    logic [1:0] slot_q;
    logic [7:0] idle_cnt_q;
    logic [7:0] idle_cnt_d;

    assign idle_cnt_d = idle_cnt_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            frame_q      <= 4'b0000;
            dout_q       <= 4'b0000;
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
            slot_q       <= 2'd0;
            idle_cnt_q   <= 8'd0;
        end else begin
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (din_valid && sync) begin
                        frame_q    <= {3'b000, din};
                        slot_q     <= 2'd1;
                        idle_cnt_q <= 8'd0;
                        state_q    <= ST_RECV;
                    end
                end
                default: begin
                    if (din_valid) begin
                        idle_cnt_q <= 8'd0;
                        // Resync wins over completion of the current frame.
                        if (sync) begin
                            err_q   <= 1'b1;
                            frame_q <= {3'b000, din};
                            slot_q  <= 2'd1;
                            state_q <= ST_RECV;
                        end
`ifdef TDM_DEMUX_PARITY_EN
                        else if (state_q == ST_PAR) begin
                            if (din == ^frame_q) begin
                                dout_q       <= frame_q;
                                dout_valid_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                            frame_q <= 4'b0000;
                            slot_q  <= 2'd0;
                            state_q <= ST_IDLE;
                        end
`endif
                        else if (slot_q == 2'd3) begin
`ifdef TDM_DEMUX_PARITY_EN
                            frame_q[3] <= din;
                            state_q    <= ST_PAR;
`else
                            dout_q       <= {din, frame_q[2:0]};
                            dout_valid_q <= 1'b1;
                            frame_q      <= 4'b0000;
                            slot_q       <= 2'd0;
                            state_q      <= ST_IDLE;
`endif
                        end else begin
                            frame_q[slot_q] <= din;
                            slot_q          <= slot_q + 2'd1;
                        end
                    end else if (idle_cnt_d == LIMIT) begin
                        err_q      <= 1'b1;
                        frame_q    <= 4'b0000;
                        slot_q     <= 2'd0;
                        idle_cnt_q <= 8'd0;
                        state_q    <= ST_IDLE;
                    end else begin
                        idle_cnt_q <= idle_cnt_d;
                    end
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign slot       = slot_q;
    assign err        = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Randomized self-checking bench for tdm_demux4 against a queue-based frame model.
// Honours TDM_DEMUX_PARITY_EN so the same bench covers both builds.
module tb_tdm_demux4;
    localparam int IDLE_LIMIT = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       din, din_valid, sync;
    logic [3:0] dout;
    logic       dout_valid;
    logic [1:0] slot;
    logic       err;

    int errors = 0;
    int checks = 0;
    int err_seen = 0;
    int dv_seen = 0;

    // Reference model state: bits of the frame in progress, kept as a queue.
    bit         in_frame;
    bit         q[$];
    int         idle;
    logic [3:0] m_dout;
    logic       m_dv, m_err;

    tdm_demux4 #(.IDLE_LIMIT(IDLE_LIMIT)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
        .dout(dout), .dout_valid(dout_valid), .slot(slot), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        in_frame = 0; q.delete(); idle = 0; m_dout = 4'b0000; m_dv = 0; m_err = 0;
    endfunction

    function automatic logic [1:0] m_slot();
        if (!in_frame) return 2'd0;
        return (q.size() > 3) ? 2'd3 : 2'(q.size());
    endfunction

    function automatic void model_step(bit d, bit v, bit s);
        m_dv = 0; m_err = 0;
        if (!in_frame) begin
            if (v && s) begin in_frame = 1; q = {d}; idle = 0; end
        end else if (v) begin
            idle = 0;
            if (s) begin
                m_err = 1; q = {d};
            end else begin
                q.push_back(d);
                if (q.size() == (PAR_EN ? 5 : 4)) begin
                    if (!PAR_EN || (q[4] == (q[0] ^ q[1] ^ q[2] ^ q[3]))) begin
                        m_dout = {q[3], q[2], q[1], q[0]};
                        m_dv = 1;
                    end else begin
                        m_err = 1;
                    end
                    in_frame = 0; q.delete();
                end
            end
        end else begin
            idle++;
            if (idle >= IDLE_LIMIT) begin m_err = 1; in_frame = 0; q.delete(); idle = 0; end
        end
    endfunction

    // One clock: drive, advance model, sample 1 time unit after the edge.
    task automatic step(input bit d, input bit v, input bit s);
        din = d; din_valid = v; sync = s;
        model_step(d, v, s);
        @(posedge clk); #1;
        chk("dout", 8'(dout), 8'(m_dout));
        chk("dout_valid", 8'(dout_valid), 8'(m_dv));
        chk("slot", 8'(slot), 8'(m_slot()));
        chk("err", 8'(err), 8'(m_err));
        chk("err_dv_excl", 8'(dout_valid & err), 8'd0);
        if (err) err_seen++;
        if (dout_valid) dv_seen++;
    endtask

    task automatic frame4(input logic [3:0] b, input int gap);
        for (int k = 0; k < 4; k++) begin
            step(b[k], 1'b1, k == 0);
            if (k < 3) for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
        end
        if (PAR_EN) step(^b, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_dout", 8'(dout), 8'd0);
        chk("rst_dv", 8'(dout_valid), 8'd0);
        chk("rst_slot", 8'(slot), 8'd0);
        chk("rst_err", 8'(err), 8'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int gap;
        int r;
        din = 0; din_valid = 0; sync = 0;
        model_reset();
        do_reset();
        step(0, 0, 0);

        // Basic frame 0,1,0,1 -> 4'b1010
        frame4(4'b1010, 0);
        chk("basic_dout", 8'(dout), 8'h0A);
        chk("basic_dv", 8'(dout_valid), 8'd1);
        step(0, 0, 0);
        chk("basic_dv_oneshot", 8'(dout_valid), 8'd0);

        // Frame 1,1,0,0 with 3-cycle gaps -> 4'b0011, no err
        err_seen = 0;
        frame4(4'b0011, 3);
        chk("gap_dout", 8'(dout), 8'h03);
        chk("gap_no_err", 8'(err_seen), 8'd0);

        // Two beats then resync with din=1, then 1,1,1
        step(0, 1, 1); step(0, 1, 0);
        step(1, 1, 1);
        chk("resync_err", 8'(err), 8'd1);
        step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
        if (PAR_EN) step(1'b0, 1, 0);
        chk("resync_dout", 8'(dout), 8'h0F);

        // Sync then IDLE_LIMIT idle cycles -> timeout, then stray beats ignored
        step(1, 1, 1);
        for (int k = 0; k < IDLE_LIMIT; k++) step(0, 0, 0);
        chk("timeout_err", 8'(err), 8'd1);
        chk("timeout_slot", 8'(slot), 8'd0);
        chk("timeout_dout", 8'(dout), 8'h0F);
        dv_seen = 0;
        for (int k = 0; k < 4; k++) step(1, 1, 0);
        chk("ignore_nonsync", 8'(dv_seen), 8'd0);

        // Beat exactly at the limit boundary keeps the frame alive
        step(0, 1, 1);
        for (int k = 0; k < IDLE_LIMIT - 1; k++) step(0, 0, 0);
        step(1, 1, 0);
        chk("limit_beat_slot", 8'(slot), 8'd2);
        step(1, 1, 0); step(0, 1, 0);
        if (PAR_EN) step(1'b0, 1, 0);
        chk("limit_beat_dout", 8'(dout), 8'h06);

        // Back-to-back frames
        frame4(4'b1001, 0);
        frame4(4'b0110, 0);
        chk("b2b_dout", 8'(dout), 8'h06);

        // Async reset after slot 2
        step(1, 1, 1); step(1, 1, 0); step(1, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_dout", 8'(dout), 8'd0);
        chk("async_slot", 8'(slot), 8'd0);
        chk("async_err", 8'(err), 8'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        err_seen = 0; dv_seen = 0;
        step(1, 1, 0); step(1, 1, 0);
        chk("post_rst_quiet", 8'(err_seen + dv_seen), 8'd0);

`ifdef TDM_DEMUX_PARITY_EN
        // Bits 1,0,1,0 -> dout 4'b0101, parity 0 good, parity 1 bad
        step(1, 1, 1); step(0, 1, 0); step(1, 1, 0); step(0, 1, 0); step(0, 1, 0);
        chk("par_ok_dout", 8'(dout), 8'h05);
        chk("par_ok_dv", 8'(dout_valid), 8'd1);
        step(0, 0, 0);
        frame4(4'b1111, 0);
        step(1, 1, 1); step(0, 1, 0); step(1, 1, 0); step(0, 1, 0); step(1, 1, 0);
        chk("par_bad_err", 8'(err), 8'd1);
        chk("par_bad_dout", 8'(dout), 8'h0F);
`endif

        // Randomized traffic including resyncs and timeouts
        gap = 0;
        for (int i = 0; i < 3000; i++) begin
            if (gap > 0) begin
                gap--;
                step(1'($urandom), 1'b0, 1'($urandom));
            end else begin
                r = $urandom_range(0, 19);
                if (r == 0) gap = $urandom_range(1, IDLE_LIMIT + 2);
                step(1'($urandom), r < 15, r < 3);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: IDLE_LIMIT, default 8; cycles without din_valid inside a frame before the frame is aborted (legal range 2..255).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: din  input  1  serial data bit for the current slot.
REQ-005 Port: din_valid  input  1  din carries a valid bit this cycle (one bit accepted per asserted cycle).
REQ-006 Port: sync  input  1  qualified by din_valid; marks the beat as slot 0 of a new frame.
REQ-007 Port: dout  output  4  last completed frame; dout[k] = bit received in slot k.
REQ-008 Port: dout_valid  output  1  one-cycle pulse when dout is updated.
REQ-009 Port: slot  output  2  index of the next slot to be filled (0 when idle).
REQ-010 Port: err  output  1  one-cycle pulse on resync, timeout or parity failure.

Function
REQ-011 The block SHALL implement states IDLE, RECV and, when parity is compiled in, PAR.
REQ-012 In IDLE, din_valid=1 with sync=1 SHALL store din as bit 0, set slot=1 and enter RECV; din_valid without sync SHALL be ignored.
REQ-013 In RECV, din_valid=1 with sync=0 SHALL store din at position slot and increment slot.
REQ-014 Acceptance of slot 3 (parity disabled) SHALL, on the same clock edge, load dout with all four bits, assert dout_valid for exactly the following cycle, set slot=0 and return to IDLE; latency from slot-3 beat to dout_valid is 1 cycle.
REQ-015 dout SHALL hold its value between frames and never change on partial or failed frames.
REQ-016 In RECV or PAR, din_valid=1 with sync=1 SHALL discard the partial frame, pulse err, store din as bit 0, set slot=1 and remain in/enter RECV (resync takes priority over completion).
REQ-017 In RECV or PAR, an idle counter SHALL count consecutive cycles with din_valid=0 and clear on every accepted beat; reaching IDLE_LIMIT SHALL pulse err, clear the partial frame, set slot=0 and enter IDLE.
REQ-018 A beat arriving on the same cycle the idle counter reaches IDLE_LIMIT SHALL be accepted and the timeout SHALL NOT fire.
REQ-019 err and dout_valid SHALL never be asserted together.
REQ-020 Back-to-back frames (sync on the cycle directly after slot 3) SHALL be received with no lost beat.

Reset
REQ-021 rst=1 SHALL immediately, independent of clk, force state IDLE, dout=4'b0000, dout_valid=0, slot=0, err=0, and clear the idle counter and partial frame.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame with no dout_valid or err pulse; the first frame after release requires sync.

Configuration
REQ-023 Macro TDM_DEMUX_PARITY_EN SHALL, when defined, add a fifth beat after slot 3: after slot 3 the block enters PAR (slot output remains 3 during PAR).
REQ-024 With TDM_DEMUX_PARITY_EN, a valid non-sync beat in PAR equal to the XOR of the four data bits SHALL update dout and pulse dout_valid; otherwise err SHALL pulse and dout SHALL stay unchanged; both return to IDLE.
REQ-025 Without TDM_DEMUX_PARITY_EN, the PAR state and parity logic SHALL be absent and frames SHALL be four beats (REQ-014).

Verification
REQ-026 Reset, then beats din=0(sync),1,0,1 on consecutive cycles -> dout=4'b1010, one-cycle dout_valid one cycle after the fourth beat, slot=0.
REQ-027 Frame 1,1,0,0 with din_valid gaps of 3 cycles between beats (IDLE_LIMIT=8) -> dout=4'b0011, no err.
REQ-028 Two beats then sync beat din=1, followed by 1,1,1 -> err pulse at resync, then dout=4'b1111.
REQ-029 Sync beat then 8 idle cycles -> err pulse, slot=0, dout unchanged, state IDLE; later non-sync beats ignored.
REQ-030 rst asserted asynchronously after slot 2 of a frame -> all outputs zero at once; no dout_valid/err until a new sync frame.
REQ-031 With TDM_DEMUX_PARITY_EN: frame 1,0,1,0 + parity 0 -> dout=4'b0101 valid; same frame + parity 1 -> err pulse, dout held.
